// File: rtl/seg_scan_driver.sv
// Six-digit seven-segment scan driver: per-frame pattern capture, dead time between
// digits, brightness via on-time within each slot, and per-digit blinking.
module seg_scan_driver #(
    parameter int SCAN_DIV     = 1026,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] disp0,
    input  logic [6:0] disp1,
    input  logic [6:0] disp2,
    input  logic [6:0] disp3,
    input  logic [6:0] disp4,
    input  logic [6:0] disp5,
    input  logic [5:0] blink_mask,
    input  logic [2:0] bright,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int STEP = (SCAN_DIV - DEAD) / 8;
    localparam int CW   = $clog2(SCAN_DIV);
    localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] c;
    logic [2:0]    d;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          sh_valid;
    logic [6:0]    sh [6];
    logic [5:0]    blink_sh;
    logic [2:0]    bright_sh;

    logic          frame_end;
    logic          lit;
    logic [6:0]    disp_cur;
    int            c_i;
    int            on_end;

    always_comb begin
        frame_end = (c == C_LAST) && (d == 3'd5);
        c_i       = int'(c);
        on_end    = DEAD + STEP * (int'(bright_sh) + 1);
        // Anodes stay off until the first frame end has loaded real patterns.
        lit       = sh_valid && (c_i >= DEAD) && (c_i < on_end)
                    && !(blink_phase && blink_sh[d]);
        disp_cur  = 7'h7F;
        case (d)
            3'd0:    disp_cur = sh[0];
            3'd1:    disp_cur = sh[1];
            3'd2:    disp_cur = sh[2];
            3'd3:    disp_cur = sh[3];
            3'd4:    disp_cur = sh[4];
            3'd5:    disp_cur = sh[5];
            default: disp_cur = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c           <= '0;
            d           <= 3'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_valid    <= 1'b0;
            for (int i = 0; i < 6; i++) sh[i] <= 7'h7F;
            blink_sh    <= 6'b000000;
            bright_sh   <= 3'd7;
            seg         <= 7'h7F;
            an          <= 6'b111111;
            frame_tick  <= 1'b0;
        end else begin
            seg        <= lit ? disp_cur : 7'h7F;
            an         <= lit ? ~(6'b000001 << d) : 6'b111111;
            frame_tick <= frame_end;

            if (c == C_LAST) begin
                c <= '0;
                d <= (d == 3'd5) ? 3'd0 : d + 3'd1;
            end else begin
                c <= c + CW'(1);
            end

            if (frame_end) begin
                sh[0]     <= disp0;
                sh[1]     <= disp1;
                sh[2]     <= disp2;
                sh[3]     <= disp3;
                sh[4]     <= disp4;
                sh[5]     <= disp5;
                blink_sh  <= blink_mask;
                bright_sh <= bright;
                sh_valid  <= 1'b1;
                if (blink_cnt == B_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame/slot reference model driven by absolute cycle index,
// plus directed scenarios and randomized input traffic.
module tb_seg_scan_driver;

    localparam int SD    = 18;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int FRAME = 6 * SD;
    localparam int STEP  = (SD - DEAD) / 8;
    localparam int MAXF  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] disp [6];
    logic [5:0] blink_mask = 6'b0;
    logic [2:0] bright = 3'd7;
    logic [6:0] seg;
    logic [5:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DEAD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset),
        .disp0(disp[0]), .disp1(disp[1]), .disp2(disp[2]),
        .disp3(disp[3]), .disp4(disp[4]), .disp5(disp[5]),
        .blink_mask(blink_mask), .bright(bright),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: s is the cycle index since reset release; frame f shows the
    // inputs snapshotted at the end of frame f-1 (frame 0 is blank).
    int         s = 0;
    logic       model_ok = 1'b0;
    logic [6:0] exp_seg = 7'h7F;
    logic [5:0] exp_an = 6'h3F;
    logic       exp_tick = 1'b0;
    logic [6:0] cap_disp [MAXF][6];
    logic [5:0] cap_mask [MAXF];
    logic [2:0] cap_bright [MAXF];

    function automatic logic [12:0] model_out(input int si);
        int f, dg, cc, on_end;
        f  = si / FRAME;
        dg = (si / SD) % 6;
        cc = si % SD;
        if (f == 0 || f >= MAXF) return {7'h7F, 6'h3F};
        on_end = DEAD + STEP * (int'(cap_bright[f]) + 1);
        if (cc < DEAD || cc >= on_end) return {7'h7F, 6'h3F};
        if (((f / BF) % 2 == 1) && cap_mask[f][dg]) return {7'h7F, 6'h3F};
        return {cap_disp[f][dg], ~(6'b000001 << dg)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            s        <= 0;
            model_ok <= 1'b1;
            exp_seg  <= 7'h7F;
            exp_an   <= 6'h3F;
            exp_tick <= 1'b0;
        end else begin
            s <= s + 1;
            {exp_seg, exp_an} <= model_out(s);
            exp_tick <= (s % FRAME == FRAME - 1);
            if ((s % FRAME == FRAME - 1) && (s / FRAME + 1 < MAXF)) begin
                for (int i = 0; i < 6; i++) cap_disp[s / FRAME + 1][i] <= disp[i];
                cap_mask[s / FRAME + 1]   <= blink_mask;
                cap_bright[s / FRAME + 1] <= bright;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (seg !== exp_seg || an !== exp_an || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL model_cycle t=%0t got seg=%h an=%b tick=%b, want seg=%h an=%b tick=%b",
                         $time, seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            checks++;
            if ($countones(~an) > 1 || (seg !== 7'h7F && an === 6'h3F)) begin
                errors++;
                $display("FAIL onehot_blank t=%0t got an=%b seg=%h, want <=1 low anode and blank bus when off",
                         $time, an, seg);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 6'h3F || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got seg=%h an=%b tick=%b, want 7f 111111 0", seg, an, frame_tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int tick_cnt = 0, t1 = -1, t2 = -1, f1_lit = 0, f2_dead = 0;
        int lit_ok [6];
        for (int i = 0; i < 6; i++) begin
            disp[i] = 7'(7'h40 + i);
            lit_ok[i] = 0;
        end
        bright = 3'd7;
        blink_mask = 6'b0;
        do_reset();
        for (int k = 1; k <= 220; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                tick_cnt++;
                if (t1 < 0) t1 = k; else if (t2 < 0) t2 = k;
            end
            if (k <= 108 && an !== 6'h3F) f1_lit++;
            if (k >= 109 && k <= 216) begin
                if (an === 6'h3F) f2_dead++;
                for (int i = 0; i < 6; i++)
                    if (an === ~(6'b000001 << i) && seg === 7'(7'h40 + i)) lit_ok[i]++;
            end
        end
        checks++;
        if (f1_lit != 0) begin errors++; $display("FAIL basic_frame1_dark got %0d lit cycles, want 0", f1_lit); end
        checks++;
        if (t1 != 108 || t2 != 216 || tick_cnt != 2) begin
            errors++;
            $display("FAIL basic_ticks got %0d,%0d (count %0d), want 108,216 (count 2)", t1, t2, tick_cnt);
        end
        checks++;
        if (f2_dead != 12) begin errors++; $display("FAIL basic_dead got %0d, want 12", f2_dead); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (lit_ok[i] != 16) begin
                errors++;
                $display("FAIL basic_digit%0d_lit got %0d cycles, want 16", i, lit_ok[i]);
            end
        end
    endtask

    task automatic test_bright();
        for (int r = 0; r < 2; r++) begin
            int b, blank_cnt;
            int lit_cnt [6];
            b = (r == 0) ? 0 : int'($urandom_range(1, 7));
            bright = 3'(b);
            blank_cnt = 0;
            for (int i = 0; i < 6; i++) begin
                lit_cnt[i] = 0;
                disp[i] = 7'(7'h40 + i);
            end
            do_reset();
            for (int k = 1; k <= 216; k++) begin
                @(negedge clk);
                if (k >= 109) begin
                    if (seg === 7'h7F) blank_cnt++;
                    for (int i = 0; i < 6; i++) if (an === ~(6'b000001 << i)) lit_cnt[i]++;
                end
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (lit_cnt[i] != STEP * (b + 1)) begin
                    errors++;
                    $display("FAIL bright%0d_digit%0d got %0d lit cycles, want %0d", b, i, lit_cnt[i], STEP * (b + 1));
                end
            end
            checks++;
            if (blank_cnt != FRAME - 6 * STEP * (b + 1)) begin
                errors++;
                $display("FAIL bright%0d_blank got %0d, want %0d", b, blank_cnt, FRAME - 6 * STEP * (b + 1));
            end
        end
    endtask

    task automatic test_blink();
        int d2 [8];
        int d0 [8];
        for (int f = 0; f < 8; f++) begin d2[f] = 0; d0[f] = 0; end
        for (int i = 0; i < 6; i++) disp[i] = 7'(7'h40 + i);
        bright = 3'd7;
        blink_mask = 6'b000100;
        do_reset();
        for (int k = 1; k <= 7 * FRAME; k++) begin
            @(negedge clk);
            if (an === 6'b111011) d2[(k - 1) / FRAME + 1]++;
            if (an === 6'b111110) d0[(k - 1) / FRAME + 1]++;
        end
        for (int fr = 2; fr <= 7; fr++) begin
            int want2;
            want2 = (((fr - 1) / BF) % 2 == 1) ? 0 : 16;
            checks++;
            if (d2[fr] != want2) begin
                errors++;
                $display("FAIL blink_digit2_frame%0d got %0d lit cycles, want %0d", fr, d2[fr], want2);
            end
            checks++;
            if (d0[fr] != 16) begin
                errors++;
                $display("FAIL blink_digit0_frame%0d got %0d lit cycles, want 16", fr, d0[fr]);
            end
        end
        blink_mask = 6'b0;
    endtask

    task automatic test_disp_change();
        int old_cnt = 0, new_cnt = 0;
        for (int i = 0; i < 6; i++) disp[i] = 7'(7'h40 + i);
        disp[3] = 7'h12;
        bright = 3'd7;
        do_reset();
        for (int k = 1; k <= 3 * FRAME; k++) begin
            @(negedge clk);
            if (k == FRAME + SD + 5) disp[3] = 7'h34;
            if (k >= 109 && k <= 216 && an === 6'b110111 && seg === 7'h12) old_cnt++;
            if (k >= 217 && an === 6'b110111 && seg === 7'h34) new_cnt++;
        end
        checks++;
        if (old_cnt != 16) begin errors++; $display("FAIL change_old_value got %0d cycles of 12, want 16", old_cnt); end
        checks++;
        if (new_cnt != 16) begin errors++; $display("FAIL change_new_value got %0d cycles of 34, want 16", new_cnt); end
    endtask

    task automatic test_reset_mid();
        int first_k = -1;
        logic [5:0] an_first = 6'h3F;
        logic [6:0] seg_first = 7'h7F;
        logic [6:0] v;
        for (int i = 0; i < 6; i++) disp[i] = 7'($urandom_range(0, 126));
        bright = 3'd7;
        do_reset();
        for (int k = 1; k <= FRAME + 4 * SD + 9; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 6'h3F || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values got seg=%h an=%b tick=%b, want 7f 111111 0", seg, an, frame_tick);
        end
        reset = 1'b0;
        v = 7'($urandom_range(0, 126));
        disp[0] = v;
        for (int k = 1; k <= 300 && first_k < 0; k++) begin
            @(negedge clk);
            if (an !== 6'h3F) begin first_k = k; an_first = an; seg_first = seg; end
        end
        checks++;
        if (first_k != FRAME + DEAD + 1 || an_first !== 6'b111110 || seg_first !== v) begin
            errors++;
            $display("FAIL midreset_first_lit got cycle %0d an=%b seg=%h, want cycle %0d an=111110 seg=%h",
                     first_k, an_first, seg_first, FRAME + DEAD + 1, v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) disp[i] = 7'($urandom);
        bright = 3'($urandom);
        blink_mask = 6'($urandom);
        do_reset();
        for (int k = 1; k <= 8 * FRAME; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) disp[$urandom_range(0, 5)] = 7'($urandom);
            if ($urandom_range(0, 99) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 99) == 0) blink_mask = 6'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) disp[i] = 7'h7F;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bright();
        test_blink();
        test_disp_change();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
